// File: rtl/vdec_hs_fwd_if.sv
// Control, LLR-buffer and ptram signals of the HS Viterbi forward ACS stage.
// master = the controller/memory side, slave = vdec_hs_fwd.
interface vdec_hs_fwd_if #(
    parameter int LLR_W = 6
);
    logic               start;
    logic [5:0]         codeblk_size_p7;
    logic               busy;
    logic               done;
    logic               llr_rd;
    logic [5:0]         llr_addr;
    logic [3*LLR_W-1:0] llr_dout;
    logic               pt_wr;
    logic [8:0]         pt_addr;
    logic [31:0]        pt_din;

    modport master (
        output start, codeblk_size_p7, llr_dout,
        input  busy, done, llr_rd, llr_addr, pt_wr, pt_addr, pt_din
    );

    modport slave (
        input  start, codeblk_size_p7, llr_dout,
        output busy, done, llr_rd, llr_addr, pt_wr, pt_addr, pt_din
    );
endinterface

// File: rtl/vdec_hs_fwd.sv
// Forward add-compare-select for the rate-1/3 K=9 HS Viterbi decoder.
// Optional macro VDEC_HS_FWD_LLR_SAT_EN folds the most negative LLR onto a symmetric range.
module vdec_hs_fwd #(
    parameter int LLR_W = 6,
    parameter int PM_W  = 12
) (
    input  logic           clk,
    input  logic           rst,
    vdec_hs_fwd_if.slave   bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_ACS  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [8:0] G0 = 9'o557;
    localparam logic [8:0] G1 = 9'o663;
    localparam logic [8:0] G2 = 9'o711;

    localparam logic [PM_W-1:0] PM_INIT = PM_W'(-512);
    localparam logic [5:0]      L_MAX   = 6'd36;
`ifdef VDEC_HS_FWD_LLR_SAT_EN
    localparam logic [LLR_W-1:0] LLR_MIN = {1'b1, {(LLR_W-1){1'b0}}};
    localparam logic [LLR_W-1:0] LLR_SYM = {1'b1, {(LLR_W-2){1'b0}}, 1'b1};
`endif

    // Bit k of the result is coded bit ck for encoder register {s, b}.
    function automatic logic [2:0] cw(input logic [7:0] s, input logic b);
        logic [8:0] c;
        c = {s, b};
        return {^(c & G2), ^(c & G1), ^(c & G0)};
    endfunction

    logic [2:0]      state_q, state_d;
    logic [5:0]      t_q, t_d;
    logic [2:0]      g_q, g_d;
    logic [5:0]      len_q, len_d;
    logic            bank_q, bank_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            llr_rd_q, llr_rd_d;
    logic [5:0]      llr_addr_q, llr_addr_d;
    logic            pt_wr_q, pt_wr_d;
    logic [8:0]      pt_addr_q, pt_addr_d;
    logic [31:0]     pt_din_q, pt_din_d;
    logic [PM_W-1:0] bm_q [8];
    logic [PM_W-1:0] bm_d [8];
    logic [PM_W-1:0] pm_q [2][256];

    logic            accept;
    logic [PM_W-1:0] acs_pm [32];
    logic [31:0]     surv;

    assign accept = bus.start && (state_q == S_IDLE) && !busy_q;

    // Branch metrics for the 8 code words, from the LLRs on the bus this cycle.
    logic [PM_W-1:0] bm_c [8];
    always_comb begin
        logic [LLR_W-1:0] l;
        logic [PM_W-1:0]  lx [3];
        logic [2:0]       wv;
        l  = '0;
        wv = '0;
        for (int k = 0; k < 3; k++) begin
            l = bus.llr_dout[k*LLR_W +: LLR_W];
`ifdef VDEC_HS_FWD_LLR_SAT_EN
            if (l == LLR_MIN) l = LLR_SYM;
`endif
            lx[k] = {{(PM_W-LLR_W){l[LLR_W-1]}}, l};
        end
        for (int w = 0; w < 8; w++) begin
            wv      = 3'(w);
            bm_c[w] = '0;
            for (int k = 0; k < 3; k++)
                bm_c[w] = wv[k] ? bm_c[w] - lx[k] : bm_c[w] + lx[k];
        end
    end

    // 32 butterflies for group g: predecessors share s[7:1], differ in the top bit.
    always_comb begin
        logic [7:0]      s;
        logic [PM_W-1:0] m0, m1, dlt;
        logic            sel;
        s    = '0;
        m0   = '0;
        m1   = '0;
        dlt  = '0;
        sel  = 1'b0;
        surv = '0;
        for (int j = 0; j < 32; j++) begin
            s   = {g_q, 5'(j)};
            m0  = pm_q[bank_q][{1'b0, s[7:1]}] + bm_q[cw(s, 1'b0)];
            m1  = pm_q[bank_q][{1'b1, s[7:1]}] + bm_q[cw(s, 1'b1)];
            dlt = m1 - m0;
            sel = (dlt != '0) && !dlt[PM_W-1];
            acs_pm[j] = sel ? m1 : m0;
            surv[j]   = sel;
        end
    end

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        g_d        = g_q;
        len_d      = len_q;
        bank_d     = bank_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        llr_rd_d   = 1'b0;
        llr_addr_d = llr_addr_q;
        pt_wr_d    = 1'b0;
        pt_addr_d  = pt_addr_q;
        pt_din_d   = pt_din_q;
        bm_d       = bm_q;
        case (state_q)
            S_IDLE: begin
                busy_d = accept;
                if (accept) begin
                    state_d    = S_RD;
                    t_d        = '0;
                    len_d      = (bus.codeblk_size_p7 > L_MAX) ? L_MAX : bus.codeblk_size_p7;
                    llr_rd_d   = 1'b1;
                    llr_addr_d = '0;
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                bm_d    = bm_c;
                g_d     = '0;
                state_d = S_ACS;
            end
            S_ACS: begin
                pt_wr_d   = 1'b1;
                pt_addr_d = {t_q, g_q};
                pt_din_d  = surv;
                g_d       = g_q + 3'd1;
                if (g_q == 3'd7) begin
                    bank_d = ~bank_q;
                    if (t_q == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        t_d        = t_q + 6'd1;
                        llr_rd_d   = 1'b1;
                        llr_addr_d = t_q + 6'd1;
                        state_d    = S_RD;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            g_q        <= '0;
            len_q      <= '0;
            bank_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            llr_rd_q   <= 1'b0;
            llr_addr_q <= '0;
            pt_wr_q    <= 1'b0;
            pt_addr_q  <= '0;
            pt_din_q   <= '0;
            for (int w = 0; w < 8; w++) bm_q[w] <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            g_q        <= g_d;
            len_q      <= len_d;
            bank_q     <= bank_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            llr_rd_q   <= llr_rd_d;
            llr_addr_q <= llr_addr_d;
            pt_wr_q    <= pt_wr_d;
            pt_addr_q  <= pt_addr_d;
            pt_din_q   <= pt_din_d;
            bm_q       <= bm_d;
        end
    end

    // Start seeds the bank about to be read; ACS fills the other bank one group at a time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int s = 0; s < 256; s++)
                    pm_q[b][s] <= '0;
        end else if (accept) begin
            for (int s = 0; s < 256; s++)
                pm_q[bank_q][s] <= (s == 0) ? '0 : PM_INIT;
        end else if (state_q == S_ACS) begin
            for (int j = 0; j < 32; j++)
                pm_q[~bank_q][{g_q, 5'(j)}] <= acs_pm[j];
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.llr_rd   = llr_rd_q;
    assign bus.llr_addr = llr_addr_q;
    assign bus.pt_wr    = pt_wr_q;
    assign bus.pt_addr  = pt_addr_q;
    assign bus.pt_din   = pt_din_q;
endmodule

// File: tb/tb_vdec_hs_fwd.sv
// Scoreboard bench for vdec_hs_fwd: a behavioural trellis model queues expected ptram writes,
// a monitor pops them as the DUT writes; control timing is checked cycle by cycle.
module tb_vdec_hs_fwd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   s_cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          addr;
        logic [31:0] din;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [17:0] llr_mem [64];
    int          gen [3] = '{9'o557, 9'o663, 9'o711};

    vdec_hs_fwd_if #(.LLR_W(6)) ifc();

    vdec_hs_fwd #(.LLR_W(6), .PM_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc - s_cyc);
        end
    endfunction

    // LLR buffer: data appears one cycle after the read strobe.
    initial begin
        logic [5:0] a;
        ifc.llr_dout = '0;
        forever begin
            @(negedge clk);
            if (ifc.llr_rd) begin
                a = ifc.llr_addr;
                @(posedge clk);
                #1 ifc.llr_dout = llr_mem[a];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (ifc.pt_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pt_wr_unexpected got_addr=%0d want=none", ifc.pt_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pt_addr", 64'(ifc.pt_addr), 64'(e.addr));
                chk("pt_din", 64'(ifc.pt_din), 64'(e.din));
                chk("pt_cycle", 64'(cyc - s_cyc), 64'(e.cyc));
            end
        end
    end

    function automatic int llr_of(input int t, input int k);
        logic signed [5:0] v;
        int r;
        v = $signed(llr_mem[t][6*k +: 6]);
        r = int'(v);
`ifdef VDEC_HS_FWD_LLR_SAT_EN
        if (r == -32) r = -31;
`endif
        return r;
    endfunction

    function automatic int md(input int x);
        return ((x % 4096) + 4096) % 4096;
    endfunction

    // Reference trellis: metrics as integers mod 4096, larger metric wins, ties go to p0.
    task automatic build_expect(input int L);
        int pm [256];
        int nx [256];
        int m [2];
        logic [31:0] word [8];
        exp_t e;
        for (int s = 0; s < 256; s++) pm[s] = (s == 0) ? 0 : 4096 - 512;
        for (int t = 0; t <= L; t++) begin
            for (int g = 0; g < 8; g++) word[g] = '0;
            for (int s = 0; s < 256; s++) begin
                int d;
                for (int b = 0; b < 2; b++) begin
                    int c;
                    c = s * 2 + b;
                    m[b] = pm[b * 128 + s / 2];
                    for (int k = 0; k < 3; k++)
                        m[b] += ($countones(c & gen[k]) % 2 == 1) ? -llr_of(t, k) : llr_of(t, k);
                    m[b] = md(m[b]);
                end
                d = md(m[1] - m[0]);
                if (d != 0 && d < 2048) begin
                    nx[s] = m[1];
                    word[s / 32][s % 32] = 1'b1;
                end else begin
                    nx[s] = m[0];
                end
            end
            for (int g = 0; g < 8; g++) begin
                e.addr = t * 8 + g;
                e.din  = word[g];
                e.cyc  = 4 + 10 * t + g;
                exp_q.push_back(e);
            end
            pm = nx;
        end
    endtask

    task automatic fill_const(input int v);
        logic [5:0] x;
        x = v[5:0];
        for (int t = 0; t < 64; t++) llr_mem[t] = {x, x, x};
    endtask

    task automatic fill_rand();
        for (int t = 0; t < 64; t++) llr_mem[t] = 18'($urandom);
    endtask

    // Encode 29 random bits + 8 zero tail bits, map to +/-20, flip three soft bits.
    task automatic fill_encoded();
        int st, ns, u, c, t, k;
        logic [5:0] v;
        st = 0;
        for (int i = 0; i < 64; i++) llr_mem[i] = '0;
        for (int i = 0; i <= 36; i++) begin
            u  = (i < 29) ? int'($urandom_range(0, 1)) : 0;
            ns = ((st << 1) | u) & 255;
            c  = ns * 2 + (st >> 7);
            for (int j = 0; j < 3; j++) begin
                v = ($countones(c & gen[j]) % 2 == 1) ? 6'(-20) : 6'(20);
                llr_mem[i][6*j +: 6] = v;
            end
            st = ns;
        end
        for (int f = 0; f < 3; f++) begin
            t = int'($urandom_range(0, 36));
            k = int'($urandom_range(0, 2));
            v = llr_mem[t][6*k +: 6];
            llr_mem[t][6*k +: 6] = -v;
        end
    endtask

    // mode 0: plain run; 1: extra starts while busy and coincident with done; 2: reset in stage 5.
    task automatic run(input int lin, input int mode);
        int L, last;
        L    = (lin > 36) ? 36 : lin;
        last = (mode == 2) ? 70 : 14 + 10 * L;
        build_expect(L);
        @(posedge clk);
        #1;
        ifc.codeblk_size_p7 = 6'(lin);
        ifc.start = 1'b1;
        s_cyc = cyc;
        for (int rel = 1; rel <= last; rel++) begin
            @(posedge clk);
            #1;
            ifc.start = (mode == 1) && (rel == 30 || rel == 12 + 10 * L);
            if (mode == 2) rst = (rel >= 55 && rel < 58);
            @(negedge clk);
            if (mode == 2 && rel >= 55) begin
                chk("rst_busy", 64'(ifc.busy), 64'(0));
                chk("rst_done", 64'(ifc.done), 64'(0));
                chk("rst_llr_rd", 64'(ifc.llr_rd), 64'(0));
                chk("rst_pt_wr", 64'(ifc.pt_wr), 64'(0));
                if (rel == 55) begin
                    chk("rst_pt_addr", 64'(ifc.pt_addr), 64'(0));
                    chk("rst_pt_din", 64'(ifc.pt_din), 64'(0));
                    chk("rst_llr_addr", 64'(ifc.llr_addr), 64'(0));
                end
            end else begin
                chk("busy", 64'(ifc.busy), 64'(rel <= 12 + 10 * L));
                chk("done", 64'(ifc.done), 64'(rel == 12 + 10 * L));
                chk("llr_rd", 64'(ifc.llr_rd), 64'(((rel - 1) % 10 == 0) && rel <= 1 + 10 * L));
                if (ifc.llr_rd) chk("llr_addr", 64'(ifc.llr_addr), 64'((rel - 1) / 10));
            end
        end
        if (mode == 2) exp_q.delete();
        else chk("writes_missing", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.codeblk_size_p7 = '0;
        fill_const(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(ifc.busy), 64'(0));
        chk("reset_done", 64'(ifc.done), 64'(0));
        chk("reset_llr_rd", 64'(ifc.llr_rd), 64'(0));
        chk("reset_llr_addr", 64'(ifc.llr_addr), 64'(0));
        chk("reset_pt_wr", 64'(ifc.pt_wr), 64'(0));
        chk("reset_pt_addr", 64'(ifc.pt_addr), 64'(0));
        chk("reset_pt_din", 64'(ifc.pt_din), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        fill_const(31);  run(36, 0);
        fill_rand();     run(8, 1);
        fill_const(0);   run(20, 0);
        fill_encoded();  run(36, 0);
        fill_rand();     run(50, 0);
        fill_const(31);  run(36, 2);
        fill_const(31);  run(36, 0);
        fill_const(-32); run(8, 0);
        fill_const(-31); run(8, 0);
        fill_rand();     run(12, 1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
